bus_arb_mux: RTL
================

# bus_arb_mux

Parametrised, registered N-source bus multiplexer with built-in arbitration for the LC-3 datapath bus. It replaces fixed-select bus muxing where several sources (PC, MDR, ALU, MARMUX, and future peripherals) can request the bus in the same cycle. It arbitrates the requests and registers the winner's data with a valid flag. It also supports locked multi-cycle ownership, a legacy forced-select path, and a saturating conflict counter for debug.

## Interface
- WIDTH, 16, data width of each source and of the output
- N, 4, number of sources (2..16)
- MODE, ARB_RR, arbitration policy: ARB_FIXED (lowest index wins) or ARB_RR (round-robin)
- Clk  in  1  system clock, rising-edge
- Reset_n  in  1  asynchronous, active-low reset
- req  in  N  per-source bus request
- lock  in  N  per-source ownership hold; meaningful only for the currently granted source
- D_in  in  N×WIDTH  packed source data, D_in[i] belongs to source i
- force_en  in  1  legacy override: select by index, bypass arbitration
- force_sel  in  $clog2(N)  source index used when force_en=1
- clr_cnt  in  1  synchronous clear of conflict_cnt
- D_out  out  WIDTH  registered bus data
- valid  out  1  D_out was loaded on the last edge
- grant  out  N  registered one-hot grant (all zero when idle)
- conflict_cnt  out  8  saturating count of contended cycles

## Operation
- State: grant_q (one-hot or zero), rr_ptr ($clog2(N) bits), conflict_cnt.
  - FSM view:
    - IDLE: grant_q=0.
    - OWN: grant_q one-hot, not locked.
    - LOCKED: grant_q[i], req[i] and lock[i] all high.
- Winner selection (combinational, per cycle), in priority order:
  1. force_en=1: winner = force_sel. If force_sel ≥ N, there is no winner.
  2. LOCKED (grant_q[i] & req[i] & lock[i]): winner = i, regardless of other requests.
  3. ARB_FIXED: lowest-index set bit of req.
  4. ARB_RR: first set bit of req scanning from rr_ptr upward, wrapping modulo N.
  5. req=0: no winner.
- On each edge with a winner w:
  - D_out ← D_in[w]; valid ← 1; grant ← onehot(w).
  - rr_ptr ← (w+1) mod N, but only for arbitrated or locked wins. A forced win leaves rr_ptr unchanged.
- On each edge with no winner:
  - valid ← 0; grant ← 0.
  - D_out holds its previous value. It is not zeroed.
- lock is ignored unless the same source is already granted and still requesting. Dropping req[i] or lock[i] releases ownership; arbitration resumes in the same cycle.
- conflict_cnt:
  - Increments when force_en=0 and popcount(req) ≥ 2, including cycles where a lock resolves the contention.
  - Saturates at 8'hFF.
  - clr_cnt=1 clears it to 0 and takes precedence over a simultaneous increment.

## Timing
- Reset (Reset_n low, asynchronous): D_out=0, valid=0, grant=0, rr_ptr=0, conflict_cnt=0. Outputs take these values immediately, not at the next edge.
- Deassertion of Reset_n is sampled at the next Clk edge. The first grant can appear on the first edge after release.
- Latency: inputs sampled at edge t appear on D_out/valid/grant after edge t, i.e. 1 cycle.
- No combinational path from any input to any output.
- Reset asserted mid-LOCKED: ownership is lost. After release, arbitration restarts from rr_ptr=0.
- When force_en is asserted, the change takes effect on the next edge. Any existing lock is preempted for that cycle and is not restored afterwards unless the lock conditions still hold.
- Wrap-around: an RR scan from rr_ptr=N-1 continues at index 0.

## Structure
- Package bus_mux_pkg:
  - enum arb_mode_e {ARB_FIXED, ARB_RR}.
  - localparam CNT_W=8.
  - function onehot(idx, N).
- Sub-module rr_pick:
  - Parameter N; inputs req and start; outputs found and idx.
  - Rotating priority picker. start=0 gives fixed priority, so ARB_FIXED mode reuses it.

## Test plan
All scenarios use N=4, WIDTH=16.

1. Reset: hold Reset_n=0 with req=4'hF and clocks running → D_out=16'h0000, valid=0, grant=0, conflict_cnt=0. Assert reset between edges → outputs clear without waiting for Clk.
2. Fixed priority (MODE=ARB_FIXED): req=4'b1010, D_in[1]=16'h1111, D_in[3]=16'h3333 for one cycle → next cycle D_out=16'h1111, grant=4'b0010, valid=1, conflict_cnt=1. The following cycle, with req=0 → valid=0, D_out still 16'h1111.
3. Round-robin: req=4'hF held 5 cycles from reset → grants 0001, 0010, 0100, 1000, 0001; conflict_cnt=5.
4. Lock: source 2 granted; then req=4'b0101 with lock=4'b0100 for 3 cycles → grant stays 4'b0100. Drop lock[2] → next grant 4'b0001 (rr_ptr=3 scans and wraps to 0).
5. Force: force_en=1, force_sel=2'd3, req=4'b0001, D_in[3]=16'hBEEF → D_out=16'hBEEF, grant=4'b1000, conflict_cnt unchanged, rr_ptr unchanged. Then force_en=0 → source 0 granted.
6. Counter saturation: req=4'b0011 for 300 cycles → conflict_cnt=8'hFF. Assert clr_cnt together with continued contention → counter reads 0 the next cycle, then increments again.

Source files
------------

// File: rtl/bus_arb_mux_pkg.sv
// Shared types, constants and helpers for the arbitrated LC-3 bus multiplexer.
// Imported by the interface, the picker and the top level.
package bus_mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Ownership classification of the current cycle, derived from grant_q/req/lock.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_LOCKED = 2'd2
    } bus_state_e;

    localparam int CNT_W = 8;
    localparam int MAX_N = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        if (idx < n) begin
            r[idx[3:0]] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arb_mux_if.sv
// Bus-side signal bundle of bus_arb_mux: source requests/data in, registered bus out.
// master drives the sources, slave is the multiplexer itself.
interface bus_arb_mux_if
    import bus_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4
) ();
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]            req;
    logic [N-1:0]            lock;
    logic [N-1:0][WIDTH-1:0] D_in;
    logic                    force_en;
    logic [IDX_W-1:0]        force_sel;
    logic                    clr_cnt;
    logic [WIDTH-1:0]        D_out;
    logic                    valid;
    logic [N-1:0]            grant;
    logic [CNT_W-1:0]        conflict_cnt;

    modport master (
        output req, lock, D_in, force_en, force_sel, clr_cnt,
        input  D_out, valid, grant, conflict_cnt
    );

    modport slave (
        input  req, lock, D_in, force_en, force_sel, clr_cnt,
        output D_out, valid, grant, conflict_cnt
    );
endinterface

// File: rtl/bus_arb_mux_rr_pick.sv
// Rotating-priority picker: first set request scanning upward from start, wrapping at N.
// With start tied to zero it degenerates to plain lowest-index-wins priority.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    // cand[k] is the source index examined k steps after start.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum       = {1'b0, start} + (IDX_W+1)'(gi);
        assign cand[gi]  = (32'(sum) >= N) ? IDX_W'(32'(sum) - N) : sum[IDX_W-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end
endmodule

// File: rtl/bus_arb_mux.sv
// Registered N-source bus multiplexer with forced select, locked ownership,
// fixed or round-robin arbitration, and a saturating contention counter.
module bus_arb_mux
    import bus_mux_pkg::*;
#(
    parameter int        WIDTH = 16,
    parameter int        N     = 4,
    parameter arb_mode_e MODE  = ARB_RR
) (
    input  logic          Clk,
    input  logic          Reset_n,
    bus_arb_mux_if.slave  bus
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]       grant_q,  grant_d;
    logic [WIDTH-1:0]   d_out_q,  d_out_d;
    logic               valid_q,  valid_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic [N-1:0]       lock_vec;
    logic [IDX_W-1:0]   lock_idx;
    logic [IDX_W-1:0]   pick_start;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    bus_state_e         arb_state;

    logic               win_found;
    logic               win_forced;
    logic [IDX_W-1:0]   win_idx;
    logic [MAX_N-1:0]   win_oh;

    // A lock only counts for the source that already holds the bus and still requests it.
    for (genvar gi = 0; gi < N; gi++) begin : g_lock
        assign lock_vec[gi] = grant_q[gi] & bus.req[gi] & bus.lock[gi];
    end

    always_comb begin
        lock_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (lock_vec[i]) begin
                lock_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        arb_state = ST_IDLE;
        if (|lock_vec) begin
            arb_state = ST_LOCKED;
        end else if (|grant_q) begin
            arb_state = ST_OWN;
        end
    end

    assign pick_start = (MODE == ARB_FIXED) ? '0 : rr_ptr_q;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req   (bus.req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Winner priority: forced select, then held lock, then arbitration.
    always_comb begin
        win_found  = 1'b0;
        win_forced = 1'b0;
        win_idx    = '0;
        if (bus.force_en) begin
            if (int'(bus.force_sel) < N) begin
                win_found  = 1'b1;
                win_forced = 1'b1;
                win_idx    = bus.force_sel;
            end
        end else if (arb_state == ST_LOCKED) begin
            win_found = 1'b1;
            win_idx   = lock_idx;
        end else if (pick_found) begin
            win_found = 1'b1;
            win_idx   = pick_idx;
        end
    end

    always_comb begin
        grant_d  = '0;
        valid_d  = 1'b0;
        d_out_d  = d_out_q;
        rr_ptr_d = rr_ptr_q;
        win_oh   = onehot(32'(win_idx), N);
        if (win_found) begin
            d_out_d = bus.D_in[win_idx];
            valid_d = 1'b1;
            grant_d = win_oh[N-1:0];
            if (!win_forced) begin
                rr_ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + IDX_W'(1);
            end
        end
    end

    // Lock-resolved contention still counts; forced cycles never do.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (!bus.force_en && ($countones(bus.req) > 1) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            grant_q  <= '0;
            d_out_q  <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            grant_q  <= grant_d;
            d_out_q  <= d_out_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.D_out        = d_out_q;
    assign bus.valid        = valid_q;
    assign bus.grant        = grant_q;
    assign bus.conflict_cnt = cnt_q;
endmodule
